// File: rtl/vga_pkg.sv
// Shared constants and fetch-FSM state encoding for the character pixel path.
package vga_pkg;

  localparam int AW_DEFAULT = 10;
  localparam int GLYPH_W    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISP_RD   = 2'd1,
    DISP_WAIT = 2'd2,
    HOST_WR   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/glyph_reg_mux.sv
// Holds the fetched glyph row and selects the pixel for the current column.
module glyph_reg_mux
  import vga_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [GLYPH_W-1:0] loadData_i,
  input  logic [2:0]         colSel_i,
  output logic               bitDisp_o
);

  logic [GLYPH_W-1:0] glyph_q, glyph_d;

  always_comb begin
    glyph_d = glyph_q;
    if (load_i) glyph_d = loadData_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) glyph_q <= '0;
    else       glyph_q <= glyph_d;
  end

  // Bit 7 is the leftmost pixel, so column 0 maps to the MSB.
  assign bitDisp_o = glyph_q[3'd7 - colSel_i];

endmodule

// File: rtl/char_fetch_arbiter.sv
// Arbitrates the shared font memory between display glyph fetches and host writes.
// Host write path is compiled in only when HOST_WRITE_EN is defined.
module char_fetch_arbiter
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = AW_DEFAULT
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               readEn,
  input  logic [2:0]         rowCnt,
  input  logic [6:0]         charCode,
  input  logic [3:0]         colCnt,
  input  logic               hostReq,
  input  logic [AW-1:0]      hostAddr,
  input  logic [7:0]         hostData,
  output logic               hostAck,
  output logic [AW-1:0]      memAddr,
  output logic               memRdEn,
  output logic               memWrEn,
  output logic [7:0]         memWrData,
  input  logic [GLYPH_W-1:0] memRdData,
  output logic               bitDisp,
  output logic               fetchErr
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  fetch_state_e  state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    waitCnt_q, waitCnt_d;
  logic          fetchErr_q, fetchErr_d;
  logic          glyphLoad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      waitCnt_q  <= '0;
      fetchErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      waitCnt_q  <= waitCnt_d;
      fetchErr_q <= fetchErr_d;
    end
  end

  // Display requests always win; any request that cannot be queued is an overrun.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    waitCnt_d  = waitCnt_q;
    fetchErr_d = fetchErr_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = DISP_RD;
          pend_d  = 1'b0;
          if (readEn) fetchErr_d = 1'b1;
        end else if (readEn) begin
          state_d = DISP_RD;
          addr_d  = AW'({charCode, rowCnt});
        end
`ifdef HOST_WRITE_EN
        else if (hostReq) begin
          state_d = HOST_WR;
        end
`endif
      end
      DISP_RD: begin
        state_d   = DISP_WAIT;
        waitCnt_d = '0;
        if (readEn) fetchErr_d = 1'b1;
      end
      DISP_WAIT: begin
        if (readEn) fetchErr_d = 1'b1;
        if (waitCnt_q == LAST_WAIT) state_d = IDLE;
        else                        waitCnt_d = waitCnt_q + 2'd1;
      end
`ifdef HOST_WRITE_EN
      HOST_WR: begin
        state_d = IDLE;
        if (readEn) begin
          if (pend_q) begin
            fetchErr_d = 1'b1;
          end else begin
            pend_d = 1'b1;
            addr_d = AW'({charCode, rowCnt});
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memRdEn   = 1'b0;
    memWrEn   = 1'b0;
    hostAck   = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    case (state_q)
      DISP_RD: begin
        memRdEn = 1'b1;
        memAddr = addr_q;
      end
`ifdef HOST_WRITE_EN
      HOST_WR: begin
        memWrEn   = 1'b1;
        hostAck   = 1'b1;
        memAddr   = hostAddr;
        memWrData = hostData;
      end
`endif
      default: ;
    endcase
  end

`ifndef HOST_WRITE_EN
  logic unusedHost;
  assign unusedHost = ^{hostReq, hostAddr, hostData};
`endif

  // colCnt[3] only selects the inter-character gap upstream, never a glyph bit.
  logic unusedCol;
  assign unusedCol = colCnt[3];

  assign glyphLoad = (state_q == DISP_WAIT) && (waitCnt_q == LAST_WAIT);
  assign fetchErr  = fetchErr_q;

  glyph_reg_mux uGlyph (
    .clock      (clock),
    .reset      (reset),
    .load_i     (glyphLoad),
    .loadData_i (memRdData),
    .colSel_i   (colCnt[2:0]),
    .bitDisp_o  (bitDisp)
  );

endmodule
